// File: rtl/lsq_dcache_pkg.sv
// Shared types for the LSQ data cache: FSM states, captured request, line geometry.
package rv32i_types;

    localparam int LINE_W  = 256;
    localparam int LINE_BE = LINE_W / 8;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE} dcache_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dcache_req_t;

    // Place a 4-lane word mask at word slot `sel` within a line-wide byte enable.
    function automatic logic [LINE_BE-1:0] word_be(input logic [2:0] sel, input logic [3:0] mask);
        return {28'b0, mask} << {sel, 2'b00};
    endfunction

endpackage

// File: rtl/lsq_dcache_array.sv
// Direct-mapped line storage: data/tag arrays plus valid/dirty bits (only the bits are reset).
module dcache_array
    import rv32i_types::*;
#(
    parameter int NUM_SETS = 16,
    parameter int IDX      = $clog2(NUM_SETS),
    parameter int TAG_W    = 27 - IDX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX-1:0]     rd_idx_i,
    output logic [LINE_W-1:0]  rd_data_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    input  logic [IDX-1:0]     wr_idx_i,
    input  logic               fill_i,
    input  logic               store_i,
    input  logic [LINE_BE-1:0] wr_be_i,
    input  logic [LINE_W-1:0]  wr_data_i,
    input  logic [TAG_W-1:0]   wr_tag_i
);

    logic [LINE_W-1:0]   data_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    assign rd_data_o  = data_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= 1'b0;
        end else if (store_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end
    end

    // A fill writes every byte; a store hit writes only its masked lanes.
    always_ff @(posedge clk) begin
        if (fill_i || store_i) begin
            for (int b = 0; b < LINE_BE; b++) begin
                if (wr_be_i[b]) data_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
            end
        end
        if (fill_i) tag_q[wr_idx_i] <= wr_tag_i;
    end

endmodule

// File: rtl/lsq_dcache.sv
// Blocking direct-mapped write-back/write-allocate data cache serving the LSQ data port.
module lsq_dcache
    import rv32i_types::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_rmask,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       data_in,
    output logic              data_valid,
    output logic [31:0]       dfp_addr,
    output logic              dfp_read,
    output logic              dfp_write,
    output logic [LINE_W-1:0] dfp_wdata,
    input  logic [LINE_W-1:0] dfp_rdata,
    input  logic              dfp_resp
);

    localparam int IDX   = $clog2(NUM_SETS);
    localparam int TAG_W = 27 - IDX;

    dcache_state_t state_q, state_d;
    dcache_req_t   req_q, req_d;

    logic [IDX-1:0]     idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         wsel;
    logic [LINE_W-1:0]  rd_data;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid, rd_dirty;
    logic               hit, is_store, fill, store;
    logic [31:0]        hit_word;
    logic [LINE_BE-1:0] wr_be;
    logic [LINE_W-1:0]  wr_data;
    logic               unused_bits;

    assign idx      = req_q.addr[4+IDX:5];
    assign tag      = req_q.addr[31:5+IDX];
    assign wsel     = req_q.addr[4:2];
    assign hit      = rd_valid && (rd_tag == tag);
    assign is_store = |req_q.wmask;
    assign hit_word = rd_data[{wsel, 5'b0} +: 32];
    assign wr_data  = fill ? dfp_rdata : {8{req_q.wdata}};
    assign wr_be    = fill ? '1 : word_be(wsel, req_q.wmask);
    // Load vs store is decided by wmask alone; rmask only matters for request detection.
    assign unused_bits = ^{req_q.rmask, req_q.addr[1:0]};

    dcache_array #(.NUM_SETS(NUM_SETS)) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (idx),
        .rd_data_o  (rd_data),
        .rd_tag_o   (rd_tag),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .wr_idx_i   (idx),
        .fill_i     (fill),
        .store_i    (store),
        .wr_be_i    (wr_be),
        .wr_data_i  (wr_data),
        .wr_tag_i   (tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_valid = 1'b0;
        data_in    = '0;
        dfp_read   = 1'b0;
        dfp_write  = 1'b0;
        dfp_addr   = '0;
        dfp_wdata  = '0;
        fill       = 1'b0;
        store      = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|d_rmask) || (|d_wmask)) begin
                    req_d   = '{addr: d_addr, rmask: d_rmask, wmask: d_wmask, wdata: d_wdata};
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    data_valid = 1'b1;
                    if (is_store) store = 1'b1;
                    else          data_in = hit_word;
                    state_d = IDLE;
                end else if (rd_valid && rd_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                dfp_write = 1'b1;
                dfp_addr  = {rd_tag, idx, 5'b0};
                dfp_wdata = rd_data;
                if (dfp_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                dfp_read = 1'b1;
                dfp_addr = {tag, idx, 5'b0};
                // Refill then re-run the lookup, which now hits.
                if (dfp_resp) begin
                    fill    = 1'b1;
                    state_d = LOOKUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsq_dcache.sv
// Self-checking bench for lsq_dcache: directed scenarios plus randomized traffic vs a flat-memory model.
module tb_lsq_dcache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [3:0]   d_rmask = '0;
    logic [3:0]   d_wmask = '0;
    logic [31:0]  d_wdata = '0;
    logic [31:0]  data_in;
    logic         data_valid;
    logic [31:0]  dfp_addr;
    logic         dfp_read, dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata = '0;
    logic         resp_r = 1'b0;
    logic         stray_r = 1'b0;
    wire          dfp_resp;
    assign dfp_resp = resp_r | stray_r;

    int cmp = 0;
    int errs = 0;

    lsq_dcache #(.NUM_SETS(16)) dut (
        .clk(clk), .rst_n(rst_n), .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask),
        .d_wdata(d_wdata), .data_in(data_in), .data_valid(data_valid), .dfp_addr(dfp_addr),
        .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
        .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
    );

    always #5 clk = ~clk;

    // Reference: golden = what memory should hold architecturally; backing = what DRAM holds.
    logic [255:0] golden  [logic [31:0]];
    logic [255:0] backing [logic [31:0]];
    bit           mv [16];
    bit           md [16];
    logic [22:0]  mt [16];

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'h9E37_0000 + 32'(w) * 32'h0101_0011);
        return l;
    endfunction

    function automatic logic [255:0] gline(input logic [31:0] la);
        if (golden.exists(la)) return golden[la];
        return init_line(la);
    endfunction

    function automatic logic [255:0] bline(input logic [31:0] la);
        if (backing.exists(la)) return backing[la];
        return init_line(la);
    endfunction

    // Memory-side responder.
    int resp_lat = 3;
    bit resp_en  = 1'b1;
    always begin
        @(posedge clk); #1;
        if (resp_en && rst_n && (dfp_read || dfp_write)) begin
            repeat (resp_lat) @(posedge clk);
            #1;
            if (rst_n && (dfp_read || dfp_write)) begin
                if (dfp_write) backing[dfp_addr] = dfp_wdata;
                else           dfp_rdata = bline(dfp_addr);
                resp_r = 1'b1;
                @(posedge clk); #1;
                resp_r = 1'b0;
            end
        end
    end

    // Observations and predictions from the most recent do_req.
    bit           p_hit, p_wb;
    logic [31:0]  p_wb_addr, p_data;
    logic [255:0] p_wb_line;
    int           o_n, o_rd_at, o_wr_at, o_resp_at;
    bit           o_saw_rd, o_saw_wr, o_both, o_timeout;
    logic [31:0]  o_data, o_rd_addr, o_wr_addr;
    logic [255:0] o_wr_data;
    time          o_t;

    task automatic do_req(input string nm, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
        logic [31:0]  la;
        int           idx;
        logic [22:0]  tg;
        logic [255:0] l;
        la = {a[31:5], 5'b0};
        idx = int'(a[8:5]);
        tg = a[31:9];
        p_hit     = mv[idx] && (mt[idx] == tg);
        p_wb      = !p_hit && mv[idx] && md[idx];
        p_wb_addr = {mt[idx], a[8:5], 5'b0};
        p_wb_line = gline(p_wb_addr);
        l = gline(la);
        p_data = (wm != 4'b0) ? 32'h0 : l[{a[4:2], 5'b0} +: 32];
        o_n = 0; o_rd_at = -1; o_wr_at = -1; o_resp_at = -1;
        o_saw_rd = 0; o_saw_wr = 0; o_both = 0; o_timeout = 0;
        o_data = '0; o_rd_addr = '0; o_wr_addr = '0; o_wr_data = '0;
        d_addr = a; d_rmask = rm; d_wmask = wm; d_wdata = wd;
        forever begin
            @(negedge clk);
            o_n++;
            if (dfp_read && dfp_write) o_both = 1;
            if (dfp_read && !o_saw_rd) begin o_saw_rd = 1; o_rd_addr = dfp_addr; o_rd_at = o_n; end
            if (dfp_write && !o_saw_wr) begin
                o_saw_wr = 1; o_wr_addr = dfp_addr; o_wr_data = dfp_wdata; o_wr_at = o_n;
            end
            if (dfp_resp) o_resp_at = o_n;
            if (data_valid) begin o_data = data_in; o_t = $time; break; end
            if (o_n >= 300) begin o_timeout = 1; break; end
        end
        d_rmask = '0; d_wmask = '0;
        cmp++;
        if (o_timeout || o_both) begin
            errs++;
            $display("FAIL %s protocol: timeout=%0d rd_wr_overlap=%0d, required 0/0", nm, o_timeout, o_both);
        end
        if (!o_timeout) begin
            if (!p_hit) begin mv[idx] = 1; mt[idx] = tg; md[idx] = 0; end
            if (wm != 4'b0) begin
                for (int b = 0; b < 4; b++)
                    if (wm[b]) l[{a[4:2], 5'b0} + b*8 +: 8] = wd[b*8 +: 8];
                golden[la] = l;
                md[idx] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        cmp++;
        if ({data_valid, dfp_read, dfp_write} !== 3'b000) begin
            errs++; $display("FAIL reset_ctrl: got %b, required 000", {data_valid, dfp_read, dfp_write});
        end
        cmp++;
        if (data_in !== 32'h0 || dfp_addr !== 32'h0) begin
            errs++; $display("FAIL reset_data: data_in=%h dfp_addr=%h, required 0/0", data_in, dfp_addr);
        end
        cmp++;
        if (dfp_wdata !== 256'h0) begin
            errs++; $display("FAIL reset_wdata: got %h, required 0", dfp_wdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_load;
        logic [255:0] l;
        l = init_line(32'h1000);
        l[63:32] = 32'hDEADBEEF;
        golden[32'h1000] = l;
        backing[32'h1000] = l;
        resp_lat = 3;
        do_req("cold_load", 32'h0000_1004, 4'hF, 4'h0, 32'h0);
        cmp++;
        if (!o_saw_rd || o_rd_addr !== 32'h1000 || o_saw_wr) begin
            errs++; $display("FAIL cold_load_dfp: rd=%0d addr=%h wr=%0d, required 1/00001000/0", o_saw_rd, o_rd_addr, o_saw_wr);
        end
        cmp++;
        if (o_data !== 32'hDEADBEEF) begin
            errs++; $display("FAIL cold_load_data: got %h, required deadbeef", o_data);
        end
        cmp++;
        if (o_n != o_resp_at + 1) begin
            errs++; $display("FAIL cold_load_timing: valid at %0d, required %0d", o_n, o_resp_at + 1);
        end
    endtask

    task automatic test_store_hit;
        do_req("store_hit", 32'h1004, 4'h0, 4'b0100, 32'h00AB_0000);
        cmp++;
        if (o_n != 1 || o_saw_rd || o_saw_wr || o_data !== 32'h0) begin
            errs++; $display("FAIL store_hit: lat=%0d rd=%0d wr=%0d data=%h, required 1/0/0/0", o_n, o_saw_rd, o_saw_wr, o_data);
        end
        do_req("store_readback", 32'h1004, 4'hF, 4'h0, 32'h0);
        cmp++;
        if (o_n != 1 || o_data !== 32'hDEABBEEF) begin
            errs++; $display("FAIL store_readback: lat=%0d data=%h, required 1/deabbeef", o_n, o_data);
        end
    endtask

    task automatic test_dirty_evict;
        do_req("dirty_evict", 32'h0000_1204, 4'hF, 4'h0, 32'h0);
        cmp++;
        if (!o_saw_wr || o_wr_addr !== 32'h1000 || o_wr_data[63:32] !== 32'hDEABBEEF) begin
            errs++; $display("FAIL evict_write: wr=%0d addr=%h word1=%h, required 1/00001000/deabbeef", o_saw_wr, o_wr_addr, o_wr_data[63:32]);
        end
        cmp++;
        if (!o_saw_rd || o_rd_addr !== 32'h1200 || o_rd_at <= o_wr_at) begin
            errs++; $display("FAIL evict_read: rd=%0d addr=%h rd_at=%0d wr_at=%0d, required read of 00001200 after write", o_saw_rd, o_rd_addr, o_rd_at, o_wr_at);
        end
        cmp++;
        if (o_data !== p_data) begin
            errs++; $display("FAIL evict_data: got %h, required %h", o_data, p_data);
        end
    endtask

    task automatic test_back_to_back;
        time t0, t1;
        bit  any_dfp;
        t0 = $time;
        do_req("b2b_first", 32'h1200, 4'hF, 4'h0, 32'h0);
        t1 = o_t;
        any_dfp = o_saw_rd || o_saw_wr;
        cmp++;
        if (o_data !== p_data) begin
            errs++; $display("FAIL b2b_first_data: got %h, required %h", o_data, p_data);
        end
        do_req("b2b_second", 32'h1208, 4'hF, 4'h0, 32'h0);
        any_dfp = any_dfp || o_saw_rd || o_saw_wr;
        cmp++;
        if ((t1 - t0) / 10 != 1 || (o_t - t0) / 10 != 3 || any_dfp) begin
            errs++; $display("FAIL b2b_timing: valid at N+%0d and N+%0d dfp=%0d, required N+1/N+3/0", (t1 - t0) / 10, (o_t - t0) / 10, any_dfp);
        end
        cmp++;
        if (o_data !== p_data) begin
            errs++; $display("FAIL b2b_second_data: got %h, required %h", o_data, p_data);
        end
    endtask

    task automatic test_both_masks;
        do_req("both_masks", 32'h1208, 4'hF, 4'b0001, 32'h0000_00CC);
        cmp++;
        if (o_data !== 32'h0 || o_n != 1) begin
            errs++; $display("FAIL both_masks: data=%h lat=%0d, required 0/1", o_data, o_n);
        end
        do_req("both_masks_evict", 32'h1008, 4'hF, 4'h0, 32'h0);
        cmp++;
        if (!o_saw_wr || o_wr_addr !== 32'h1200 || o_wr_data !== p_wb_line) begin
            errs++; $display("FAIL both_masks_dirty: wr=%0d addr=%h word2=%h, required 1/00001200/%h", o_saw_wr, o_wr_addr, o_wr_data[95:64], p_wb_line[95:64]);
        end
    endtask

    task automatic test_reset_mid_alloc;
        int n;
        resp_en = 1'b0;
        d_addr = 32'h1404; d_rmask = 4'hF; d_wmask = 4'h0;
        n = 0;
        while (!dfp_read && n < 50) begin @(negedge clk); n++; end
        cmp++;
        if (dfp_read !== 1'b1) begin
            errs++; $display("FAIL rst_alloc_start: dfp_read=%b, required 1", dfp_read);
        end
        #2 rst_n = 1'b0;
        #1;
        cmp++;
        if (dfp_read !== 1'b0) begin
            errs++; $display("FAIL rst_alloc_drop: dfp_read=%b, required 0", dfp_read);
        end
        cmp++;
        if (data_valid !== 1'b0 || dfp_write !== 1'b0 || dfp_addr !== 32'h0) begin
            errs++; $display("FAIL rst_alloc_outs: valid=%b write=%b addr=%h, required 0/0/0", data_valid, dfp_write, dfp_addr);
        end
        d_rmask = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 stray_r = 1'b1;
        @(posedge clk); #1 stray_r = 1'b0;
        @(negedge clk);
        cmp++;
        if ({dfp_read, dfp_write, data_valid} !== 3'b000) begin
            errs++; $display("FAIL stray_resp: rd/wr/valid=%b, required 000", {dfp_read, dfp_write, data_valid});
        end
        for (int i = 0; i < 16; i++) begin mv[i] = 0; md[i] = 0; end
        golden = backing;
        resp_en = 1'b1;
        do_req("reset_relookup", 32'h1004, 4'hF, 4'h0, 32'h0);
        cmp++;
        if (!o_saw_rd || o_rd_addr !== 32'h1000 || o_data !== 32'hDEABBEEF) begin
            errs++; $display("FAIL reset_relookup: rd=%0d addr=%h data=%h, required 1/00001000/deabbeef", o_saw_rd, o_rd_addr, o_data);
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [3:0]  rm, wm;
        int          r;
        bit          ok;
        for (int it = 0; it < 60; it++) begin
            a = 32'h0002_0000 | (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
                | (32'($urandom_range(0, 7)) << 2);
            r = $urandom_range(0, 9);
            rm = (r < 5 || r == 9) ? 4'hF : 4'h0;
            wm = (r < 5) ? 4'h0 : (r == 9) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(1, 15));
            resp_lat = $urandom_range(1, 4);
            do_req("random", a, rm, wm, $urandom);
            cmp++;
            if (o_data !== p_data) begin
                errs++; $display("FAIL rand_data it=%0d addr=%h: got %h, required %h", it, a, o_data, p_data);
            end
            if (p_hit) ok = (o_n == 1) && !o_saw_rd && !o_saw_wr;
            else ok = o_saw_rd && (o_rd_addr == {a[31:5], 5'b0}) && (o_n == o_resp_at + 1) && (o_saw_wr == p_wb)
                      && (!p_wb || (o_wr_addr == p_wb_addr && o_wr_data == p_wb_line && o_wr_at < o_rd_at));
            cmp++;
            if (!ok) begin
                errs++;
                $display("FAIL rand_traffic it=%0d addr=%h: hit_pred=%0d lat=%0d rd=%0d/%h wr=%0d/%h, required wb=%0d/%h", it, a, p_hit, o_n, o_saw_rd, o_rd_addr, o_saw_wr, o_wr_addr, p_wb, p_wb_addr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; end
        test_reset;
        test_cold_load;
        test_store_hit;
        test_dirty_evict;
        test_back_to_back;
        test_both_masks;
        test_reset_mid_alloc;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
